// File: rtl/mul_seq_pkg.sv
// Shared ALU control codes, sequencer state encodings and
// the state type used by the shift-add multiplier.
`ifndef ALU_CTL_ADD
`define ALU_CTL_AND  4'b0000
`define ALU_CTL_OR   4'b0001
`define ALU_CTL_ADD  4'b0010
`define ALU_CTL_SUB  4'b0110
`define ALU_CTL_SLT  4'b0111
`endif

`ifndef MUL_SEQ_IDLE
`define MUL_SEQ_IDLE 2'd0
`define MUL_SEQ_BUSY 2'd1
`define MUL_SEQ_DONE 2'd2
`endif

package mul_seq_pkg;

    localparam int unsigned MUL_W   = 32;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned ALU_C_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = `MUL_SEQ_IDLE,
        S_BUSY = `MUL_SEQ_BUSY,
        S_DONE = `MUL_SEQ_DONE
    } mul_state_e;

endpackage

// File: rtl/mul_seq.sv
// Sequential 32x32 shift-add multiplier borrowing the pipeline ALU.
// Define MUL_SEQ_EARLY_TERM_EN to stop once the multiplier runs out.
module mul_seq
    import mul_seq_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               Valid_i,
    output logic               Ready_o,
    input  logic [MUL_W-1:0]   A_i,
    input  logic [MUL_W-1:0]   B_i,
    input  logic               Kill_i,
    output logic               Valid_o,
    input  logic               Ready_i,
    output logic [MUL_W-1:0]   Res_o,
    output logic               AluReq_o,
    input  logic               AluGnt_i,
    output logic [ALU_C_W-1:0] AluCtl_o,
    output logic [MUL_W-1:0]   AluOp1_o,
    output logic [MUL_W-1:0]   AluOp2_o,
    input  logic [MUL_W-1:0]   AluAdderRes_i
);

    mul_state_e       state_q, state_d;
    logic [MUL_W-1:0] acc_q, acc_d;
    logic [MUL_W-1:0] mcand_q, mcand_d;
    logic [MUL_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy;
    logic             last_step;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef MUL_SEQ_EARLY_TERM_EN
    assign last_step = (cnt_q == 5'd31) || (mplier_q[MUL_W-1:1] == '0);
`else
    assign last_step = (cnt_q == 5'd31);
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (Valid_i) begin
                    acc_d    = '0;
                    mcand_d  = A_i;
                    mplier_d = B_i;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
`ifdef MUL_SEQ_EARLY_TERM_EN
                    if (B_i == '0) state_d = S_DONE;
`endif
                end
            end
            S_BUSY: begin
                if (AluGnt_i) begin
                    acc_d    = AluAdderRes_i;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 5'd1;
                    if (last_step) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (Ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // An abort freezes the datapath, so Acc keeps its pre-kill value.
        if (Kill_i) begin
            state_d  = S_IDLE;
            acc_d    = acc_q;
            mcand_d  = mcand_q;
            mplier_d = mplier_q;
            cnt_d    = cnt_q;
        end
    end

    assign busy = (state_q == S_BUSY);

    always_comb begin
        Ready_o  = (state_q == S_IDLE);
        Valid_o  = (state_q == S_DONE);
        Res_o    = acc_q;
        AluReq_o = busy;
        AluCtl_o = '0;
        AluOp1_o = '0;
        AluOp2_o = '0;
        if (busy) begin
            AluCtl_o = `ALU_CTL_ADD;
            AluOp1_o = acc_q;
            AluOp2_o = mplier_q[0] ? mcand_q : '0;
        end
    end

endmodule
